// File: rtl/mux21_readout_arbiter_pkg.sv
// Shared definitions for the readout arbiter: FSM state encoding, mux select
// values and a small helper that picks the owner's copy of a per-source signal.
package abc_rdo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GUARD   = 2'd1,
        ST_GRANT   = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    localparam logic SRC0 = 1'b0;
    localparam logic SRC1 = 1'b1;

    function automatic logic owner_bit(input logic owner, input logic bit0, input logic bit1);
        return (owner == SRC1) ? bit1 : bit0;
    endfunction

endpackage

// File: rtl/mux21_readout_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone requester wins outright, a tie goes to the
// source that did not own the line last.
module rr_pick2
    import abc_rdo_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_owner,
    output logic owner,
    output logic valid
);

    // Owner selection; defaults to source 0 when nobody is asking
    always_comb begin
        owner = SRC0;
        valid = req0 | req1;
        if (req0 && req1) begin
            owner = ~last_owner;
        end else if (req1) begin
            owner = SRC1;
        end
    end

endmodule

// File: rtl/mux21_readout_arbiter.sv
// Readout arbiter for a shared 2:1 mux: grants one serial source at a time,
// inserts idle guard cycles around select changes and caps each grant at
// MAX_HOLD cycles. Every output comes straight from a register.
module mux21_readout_arbiter
    import abc_rdo_pkg::*;
#(
    parameter int GUARD_CYCLES = 2,
    parameter int MAX_HOLD     = 255,
    parameter int CNT_W        = 8
) (
    input  logic clk,
    input  logic rstb,
    input  logic req0,
    input  logic req1,
    input  logic done0,
    input  logic done1,
    output logic gnt0,
    output logic gnt1,
    output logic sel,
    output logic idle_force,
    output logic busy,
    output logic timeout_err
);

    localparam logic [CNT_W-1:0] GUARD_LOAD = (GUARD_CYCLES > 0) ? CNT_W'(GUARD_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(MAX_HOLD - 1);

    state_t            state_q, state_n;
    logic [CNT_W-1:0]  cnt_q, cnt_n;
    logic              owner_q, owner_n;
    logic              last_q, last_n;
    logic              sel_n;
    logic              tmo_n;
    logic              gnt0_n, gnt1_n;
    logic              pick_owner, pick_valid;
    logic              req_own, done_own;

    rr_pick2 u_pick (
        .req0       (req0),
        .req1       (req1),
        .last_owner (last_q),
        .owner      (pick_owner),
        .valid      (pick_valid)
    );

    assign req_own  = owner_bit(owner_q, req0, req1);
    assign done_own = owner_bit(owner_q, done0, done1);

    // Next-state, counter, select and registered-output values
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        owner_n = owner_q;
        last_n  = last_q;
        sel_n   = sel;
        tmo_n   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    owner_n = pick_owner;
                    if (pick_owner == sel) begin
                        state_n = ST_GRANT;
                        cnt_n   = '0;
                        last_n  = pick_owner;
                    end else if (GUARD_CYCLES > 0) begin
                        sel_n   = pick_owner;
                        state_n = ST_GUARD;
                        cnt_n   = GUARD_LOAD;
                    end else begin
                        sel_n   = pick_owner;
                        state_n = ST_GRANT;
                        cnt_n   = '0;
                        last_n  = pick_owner;
                    end
                end
            end
            ST_GUARD: begin
                if (!req_own) begin
                    state_n = ST_IDLE;
                end else if (cnt_q == '0) begin
                    state_n = ST_GRANT;
                    last_n  = owner_q;
                end else begin
                    cnt_n = cnt_q - 1'b1;
                end
            end
            ST_GRANT: begin
                if (done_own || !req_own) begin
                    state_n = ST_RELEASE;
                end else if (cnt_q == HOLD_LAST) begin
                    state_n = ST_RELEASE;
                    tmo_n   = 1'b1;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            ST_RELEASE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
        gnt0_n = (state_n == ST_GRANT) && (owner_n == SRC0);
        gnt1_n = (state_n == ST_GRANT) && (owner_n == SRC1);
    end

    // State, counter and output registers with asynchronous reset
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            owner_q     <= SRC0;
            last_q      <= SRC1;
            sel         <= SRC0;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            idle_force  <= 1'b1;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state_q     <= state_n;
            cnt_q       <= cnt_n;
            owner_q     <= owner_n;
            last_q      <= last_n;
            sel         <= sel_n;
            gnt0        <= gnt0_n;
            gnt1        <= gnt1_n;
            idle_force  <= ~(gnt0_n | gnt1_n);
            busy        <= (state_n != ST_IDLE);
            timeout_err <= tmo_n;
        end
    end

endmodule
